// File: rtl/opcodes.sv
// Shared datapath select encodings for the 16-bit CPU.
package opcodes;
    typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluPassB} alu_functions_t;
    typedef enum logic [1:0] {Pc1, PcLr, PcAluOut} pc_select_t;
    typedef enum logic {Op1Rd1, Op1Pc} Op1_select_t;
endpackage

// File: rtl/sequencer.sv
// Multi-cycle control sequencer: fetch/decode, SysBus address/data handshake with wait
// states, and a latched ALU status for conditional branches.
module sequencer
    import opcodes::*;
(
    input  logic           Clock,
    input  logic           Reset,
    input  logic [9:0]     Opcode,
    input  logic [3:0]     Flags,
    input  logic           nWait,
    output alu_functions_t AluOp,
    output pc_select_t     PcSel,
    output Op1_select_t    Op1Sel,
    output logic           AluEn,
    output logic           AluWe,
    output logic           PcEn,
    output logic           PcWe,
    output logic           LrEn,
    output logic           LrWe,
    output logic           LrSel,
    output logic           SpEn,
    output logic           SpWe,
    output logic           IrWe,
    output logic           WdSel,
    output logic           ImmSel,
    output logic           RegWe,
    output logic           MemEn,
    output logic           Op2Sel,
    output logic           Rs1Sel,
    output logic           CFlag,
    output logic           ALE,
    output logic           nOE,
    output logic           nWE,
    output logic           Halted
);

    typedef enum logic [3:0] {
        StIdle, StFetch, StFdata, StExec, StMaddr, StMread, StSdata, StMwrite, StPcload, StHalt
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] stat_q, stat_d;
    logic [2:0] cls;
    logic [1:0] fn;
    logic       taken;
    logic       unused_bits;

    assign cls         = Opcode[9:7];
    assign fn          = Opcode[6:5];
    assign unused_bits = ^{Opcode[4:0], stat_q[3:2]};
    assign LrEn        = 1'b0;
    assign SpEn        = 1'b0;
    assign SpWe        = 1'b0;

    always_comb begin
        unique case (fn)
            2'b00:   taken = 1'b1;
            2'b01:   taken = stat_q[0];
            2'b10:   taken = ~stat_q[0];
            default: taken = stat_q[1];
        endcase
    end

    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        AluOp   = AluAdd;
        PcSel   = Pc1;
        Op1Sel  = Op1Rd1;
        AluEn   = 1'b0;
        AluWe   = 1'b0;
        PcEn    = 1'b0;
        PcWe    = 1'b0;
        LrWe    = 1'b0;
        LrSel   = 1'b0;
        IrWe    = 1'b0;
        WdSel   = 1'b0;
        ImmSel  = 1'b0;
        RegWe   = 1'b0;
        MemEn   = 1'b0;
        Op2Sel  = 1'b0;
        Rs1Sel  = 1'b0;
        CFlag   = 1'b0;
        ALE     = 1'b0;
        nOE     = 1'b1;
        nWE     = 1'b1;
        Halted  = 1'b0;
        // Reset overrides the decode so an aborted instruction issues no late strobes.
        if (!Reset) begin
            unique case (state_q)
                StIdle: state_d = StFetch;
                StFetch: begin
                    PcEn    = 1'b1;
                    ALE     = 1'b1;
                    state_d = StFdata;
                end
                StFdata: begin
                    nOE   = 1'b0;
                    MemEn = 1'b1;
                    if (nWait) begin
                        IrWe    = 1'b1;
                        PcWe    = 1'b1;
                        state_d = StExec;
                    end
                end
                StExec: begin
                    case (cls)
                        3'b000, 3'b001: begin
                            RegWe   = 1'b1;
                            AluOp   = alu_functions_t'({1'b0, fn});
                            CFlag   = (fn == 2'b01);
                            Rs1Sel  = (cls == 3'b000);
                            Op2Sel  = (cls == 3'b000);
                            stat_d  = Flags;
                            state_d = StFetch;
                        end
                        3'b010, 3'b011: begin
                            ImmSel  = 1'b1;
                            AluWe   = 1'b1;
                            state_d = StMaddr;
                        end
                        3'b100: begin
                            if (taken) begin
                                Op1Sel  = Op1Pc;
                                AluWe   = 1'b1;
                                state_d = StPcload;
                            end else begin
                                state_d = StFetch;
                            end
                        end
                        3'b101: begin
                            if (!Opcode[5]) begin
                                Op1Sel  = Op1Pc;
                                AluWe   = 1'b1;
                                LrSel   = 1'b1;
                                LrWe    = 1'b1;
                                state_d = StPcload;
                            end else begin
                                PcSel   = PcLr;
                                PcWe    = 1'b1;
                                state_d = StFetch;
                            end
                        end
                        3'b110:  state_d = StFetch;
                        default: state_d = StHalt;
                    endcase
                end
                StMaddr: begin
                    AluEn   = 1'b1;
                    ALE     = 1'b1;
                    state_d = (cls == 3'b011) ? StSdata : StMread;
                end
                StMread: begin
                    nOE   = 1'b0;
                    MemEn = 1'b1;
                    WdSel = 1'b1;
                    RegWe = nWait;
                    if (nWait) state_d = StFetch;
                end
                StSdata: begin
                    Op2Sel  = 1'b1;
                    AluOp   = AluPassB;
                    AluWe   = 1'b1;
                    state_d = StMwrite;
                end
                StMwrite: begin
                    AluEn = 1'b1;
                    nWE   = 1'b0;
                    if (nWait) state_d = StFetch;
                end
                StPcload: begin
                    PcSel   = PcAluOut;
                    PcWe    = 1'b1;
                    state_d = StFetch;
                end
                StHalt:  Halted = 1'b1;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StIdle;
            stat_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
        end
    end

endmodule

// File: tb/tb_sequencer.sv
// Self-checking bench for the CPU control sequencer: directed scenarios plus random
// instruction streams compared against a per-instruction timing/strobe model.
module tb_sequencer;
    import opcodes::*;

    logic           Clock = 1'b0;
    logic           Reset = 1'b1;
    logic [9:0]     Opcode = '0;
    logic [3:0]     Flags = '0;
    logic           nWait = 1'b1;
    alu_functions_t AluOp;
    pc_select_t     PcSel;
    Op1_select_t    Op1Sel;
    logic AluEn, AluWe, PcEn, PcWe, LrEn, LrWe, LrSel, SpEn, SpWe, IrWe, WdSel, ImmSel;
    logic RegWe, MemEn, Op2Sel, Rs1Sel, CFlag, ALE, nOE, nWE, Halted;

    sequencer dut (
        .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Flags(Flags), .nWait(nWait),
        .AluOp(AluOp), .PcSel(PcSel), .Op1Sel(Op1Sel), .AluEn(AluEn), .AluWe(AluWe),
        .PcEn(PcEn), .PcWe(PcWe), .LrEn(LrEn), .LrWe(LrWe), .LrSel(LrSel), .SpEn(SpEn),
        .SpWe(SpWe), .IrWe(IrWe), .WdSel(WdSel), .ImmSel(ImmSel), .RegWe(RegWe),
        .MemEn(MemEn), .Op2Sel(Op2Sel), .Rs1Sel(Rs1Sel), .CFlag(CFlag), .ALE(ALE),
        .nOE(nOE), .nWE(nWE), .Halted(Halted)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic pc_en, pc_we, alu_en, alu_we, mem_en, lr_en, sp_en, sp_we, ale, noe, nwe;
        logic reg_we, wd_sel, ir_we, rs1_sel, op2_sel, imm_sel, cflag, lr_we, lr_sel, halted;
        logic op1_pc;
        logic [1:0] pc_sel;
        logic [2:0] alu_op;
    } snap_t;

    typedef struct packed {
        int lat, regwe_n, regwe_cyc, irwe_cyc, noe_n, nwe_n, pcwe_n, lrwe_n, pclr_n;
        int cflag_n, bus_err;
    } obs_t;

    logic       w  [64];
    logic [3:0] fl [64];
    snap_t      tr [64];
    snap_t      def_s;
    logic [3:0] stat_m;
    int         n_cmp, n_err;

    function automatic snap_t grab();
        snap_t s;
        s.pc_en = PcEn;   s.pc_we = PcWe;     s.alu_en = AluEn;   s.alu_we = AluWe;
        s.mem_en = MemEn; s.lr_en = LrEn;     s.sp_en = SpEn;     s.sp_we = SpWe;
        s.ale = ALE;      s.noe = nOE;        s.nwe = nWE;        s.reg_we = RegWe;
        s.wd_sel = WdSel; s.ir_we = IrWe;     s.rs1_sel = Rs1Sel; s.op2_sel = Op2Sel;
        s.imm_sel = ImmSel; s.cflag = CFlag;  s.lr_we = LrWe;     s.lr_sel = LrSel;
        s.halted = Halted; s.op1_pc = (Op1Sel == Op1Pc);
        s.pc_sel = PcSel; s.alu_op = AluOp;
        return s;
    endfunction

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    // Per-cycle nWait and Flags; every eighth cycle forces nWait high to bound waits.
    task automatic gen_stim(input bit no_wait);
        for (int c = 0; c < 64; c++) begin
            w[c]  = no_wait ? 1'b1 : ((c % 8 == 7) ? 1'b1 : ($urandom_range(0, 2) != 0));
            fl[c] = 4'($urandom);
        end
    endtask

    // Runs one instruction from its FETCH cycle up to the next FETCH, within a cycle budget.
    task automatic run_instr(input logic [9:0] op, output obs_t o);
        snap_t s;
        o = '0;
        o.lat = -1;
        for (int c = 0; c < 48; c++) begin
            if (c > 0) next_cycle();
            Opcode = op;
            nWait  = w[c];
            Flags  = fl[c];
            #2;
            s     = grab();
            tr[c] = s;
            if ((int'(s.pc_en) + int'(s.alu_en) + int'(s.mem_en) + int'(s.lr_en)
                 + int'(s.sp_en)) > 1 || s.sp_en || s.sp_we || s.lr_en) o.bus_err++;
            if (c > 0 && s.pc_en && s.ale) begin
                o.lat = c;
                break;
            end
            if (s.reg_we) begin o.regwe_n++; o.regwe_cyc = c; end
            if (s.ir_we) o.irwe_cyc = c;
            if (!s.noe) o.noe_n++;
            if (!s.nwe) o.nwe_n++;
            if (s.pc_we) o.pcwe_n++;
            if (s.lr_we) o.lrwe_n++;
            if (s.pc_sel == PcLr) o.pclr_n++;
            if (s.cflag) o.cflag_n++;
        end
    endtask

    // Phase-list model: fixed phases take one cycle, data phases run until nWait is high.
    task automatic model(input logic [9:0] op, output obs_t e);
        int c, ex;
        logic [2:0] cls;
        logic [1:0] f;
        bit taken;
        cls = op[9:7];
        f   = op[6:5];
        e = '0;
        e.pcwe_n = 1;
        c = 1;
        while (!w[c] && c < 63) c++;
        e.irwe_cyc = c;
        e.noe_n    = c;
        ex         = c + 1;
        e.lat      = ex + 1;
        case (cls)
            3'd0, 3'd1: begin
                e.regwe_n = 1; e.regwe_cyc = ex; e.cflag_n = (f == 2'd1) ? 1 : 0;
                stat_m = fl[ex];
            end
            3'd2: begin
                c = ex + 2;
                while (!w[c] && c < 63) c++;
                e.regwe_n = 1; e.regwe_cyc = c; e.noe_n += c - ex - 1; e.lat = c + 1;
            end
            3'd3: begin
                c = ex + 3;
                while (!w[c] && c < 63) c++;
                e.nwe_n = c - ex - 2; e.lat = c + 1;
            end
            3'd4: begin
                taken = (f == 2'd0) || (f == 2'd1 && stat_m[0]) || (f == 2'd2 && !stat_m[0])
                        || (f == 2'd3 && stat_m[1]);
                if (taken) begin e.lat = ex + 2; e.pcwe_n = 2; end
            end
            3'd5: begin
                e.pcwe_n = 2;
                if (op[5]) e.pclr_n = 1;
                else begin e.lrwe_n = 1; e.lat = ex + 2; end
            end
            default: ;
        endcase
    endtask

    task automatic test_reset();
        snap_t s, e;
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            Opcode = 10'($urandom);
            nWait  = 1'($urandom);
            #2;
            s = grab();
            n_cmp++;
            if (s !== def_s) begin
                n_err++;
                $display("FAIL reset_hold[%0d] got %h want %h", i, s, def_s);
            end
        end
        next_cycle();
        Reset = 1'b0;
        #2;
        s = grab();
        n_cmp++;
        if (s !== def_s) begin
            n_err++;
            $display("FAIL idle_after_release got %h want %h", s, def_s);
        end
        next_cycle();
        #2;
        s = grab();
        e = def_s; e.pc_en = 1'b1; e.ale = 1'b1;
        n_cmp++;
        if (s !== e) begin
            n_err++;
            $display("FAIL first_fetch got %h want %h", s, e);
        end
        stat_m = '0;
    endtask

    task automatic test_alu_sub_beq();
        obs_t o, e;
        logic [9:0] op;
        op = {3'b000, 2'b01, 5'($urandom)};
        gen_stim(1'b1);
        fl[2] = 4'b0001;
        run_instr(op, o);
        model(op, e);
        n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL sub_obs got %p want %p", o, e); end
        n_cmp++;
        if ({tr[2].reg_we, tr[2].rs1_sel, tr[2].op2_sel, tr[2].cflag} !== 4'b1111) begin
            n_err++;
            $display("FAIL sub_exec_strobes got %b want 1111",
                     {tr[2].reg_we, tr[2].rs1_sel, tr[2].op2_sel, tr[2].cflag});
        end
        op = {3'b100, 2'b01, 5'($urandom)};
        gen_stim(1'b1);
        run_instr(op, o);
        model(op, e);
        n_cmp++;
        if (o.lat !== 4) begin n_err++; $display("FAIL beq_latency got %0d want 4", o.lat); end
        n_cmp++;
        if (!(tr[3].pc_we && tr[3].pc_sel == PcAluOut)) begin
            n_err++;
            $display("FAIL beq_pcload got pc_we=%b pc_sel=%0d want pc_we=1 pc_sel=%0d",
                     tr[3].pc_we, tr[3].pc_sel, PcAluOut);
        end
        op = {3'b100, 2'b10, 5'($urandom)};
        gen_stim(1'b1);
        run_instr(op, o);
        model(op, e);
        n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL bne_obs got %p want %p", o, e); end
    endtask

    task automatic test_load_wait();
        obs_t o, e;
        logic [9:0] op;
        int n_rd;
        op = {3'b010, 7'($urandom)};
        gen_stim(1'b1);
        w[4] = 1'b0;
        w[5] = 1'b0;
        run_instr(op, o);
        model(op, e);
        n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL load_obs got %p want %p", o, e); end
        n_cmp++;
        if (o.lat !== 7) begin n_err++; $display("FAIL load_latency got %0d want 7", o.lat); end
        n_rd = 0;
        for (int c = 3; c < 7; c++) if (tr[c].mem_en && !tr[c].noe) n_rd++;
        n_cmp++;
        if (n_rd !== 3) begin n_err++; $display("FAIL load_read_cycles got %0d want 3", n_rd); end
        n_cmp++;
        if (!(o.regwe_n == 1 && tr[6].reg_we && tr[6].wd_sel)) begin
            n_err++;
            $display("FAIL load_regwe got n=%0d at=%0d wd_sel=%b want n=1 at=6 wd_sel=1",
                     o.regwe_n, o.regwe_cyc, tr[6].wd_sel);
        end
    endtask

    task automatic test_store();
        obs_t o, e;
        logic [9:0] op;
        int n_mem;
        op = {3'b011, 7'($urandom)};
        gen_stim(1'b1);
        run_instr(op, o);
        model(op, e);
        n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL store_obs got %p want %p", o, e); end
        n_cmp++;
        if (!(tr[3].alu_en && tr[3].ale && tr[4].alu_we && tr[4].alu_op == AluPassB
              && !tr[5].nwe && tr[5].alu_en && o.nwe_n == 1)) begin
            n_err++;
            $display("FAIL store_phases got maddr=%h sdata=%h mwrite=%h nwe_n=%0d want phases",
                     tr[3], tr[4], tr[5], o.nwe_n);
        end
        n_mem = 0;
        for (int c = 2; c < 6; c++) if (tr[c].mem_en) n_mem++;
        n_cmp++;
        if (n_mem !== 0) begin n_err++; $display("FAIL store_memen got %0d want 0", n_mem); end
    endtask

    task automatic test_bl_ret();
        obs_t o, e;
        logic [9:0] op;
        op = {3'b101, 1'($urandom), 1'b0, 5'($urandom)};
        gen_stim(1'b1);
        run_instr(op, o);
        model(op, e);
        n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL bl_obs got %p want %p", o, e); end
        n_cmp++;
        if (!(tr[2].lr_we && tr[2].lr_sel && o.pclr_n == 0 && o.lat == 4)) begin
            n_err++;
            $display("FAIL bl_link got lr_we=%b lr_sel=%b pclr=%0d lat=%0d want 1 1 0 4",
                     tr[2].lr_we, tr[2].lr_sel, o.pclr_n, o.lat);
        end
        op = {3'b101, 1'($urandom), 1'b1, 5'($urandom)};
        gen_stim(1'b1);
        run_instr(op, o);
        model(op, e);
        n_cmp++;
        if (!(tr[2].pc_sel == PcLr && tr[2].pc_we && o.lat == 3 && o.bus_err == 0)) begin
            n_err++;
            $display("FAIL ret_pclr got pc_sel=%0d pc_we=%b lat=%0d bus=%0d want %0d 1 3 0",
                     tr[2].pc_sel, tr[2].pc_we, o.lat, o.bus_err, PcLr);
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        logic [9:0] op;
        for (int i = 0; i < 40; i++) begin
            op = {3'($urandom_range(0, 6)), 7'($urandom)};
            gen_stim(1'b0);
            run_instr(op, o);
            model(op, e);
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL rand_instr[%0d] op=%b got %p want %p", i, op, o, e);
            end
        end
    endtask

    task automatic test_halt_reset();
        snap_t s, hs, fs;
        logic [9:0] op;
        hs = def_s; hs.halted = 1'b1;
        fs = def_s; fs.pc_en = 1'b1; fs.ale = 1'b1;
        op = {3'b111, 7'($urandom)};
        for (int c = 0; c < 9; c++) begin
            if (c > 0) next_cycle();
            Opcode = op;
            nWait  = (c < 3) ? 1'b1 : 1'($urandom);
            Flags  = 4'($urandom);
            #2;
            s = grab();
            if (c >= 3) begin
                n_cmp++;
                if (s !== hs) begin n_err++; $display("FAIL halt[%0d] got %h want %h", c, s, hs); end
            end
        end
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            Reset = (c < 2);
            #2;
            s = grab();
            n_cmp++;
            if (s !== ((c == 3) ? fs : def_s)) begin
                n_err++;
                $display("FAIL halt_reset[%0d] got %h want %h", c, s, (c == 3) ? fs : def_s);
            end
        end
        stat_m = '0;
        op = {3'b010, 7'($urandom)};
        for (int c = 0; c < 7; c++) begin
            if (c > 0) next_cycle();
            Opcode = op;
            nWait  = 1'b1;
            Reset  = (c == 4);
            #2;
            s = grab();
            if (c >= 4) begin
                n_cmp++;
                if (s !== ((c == 6) ? fs : def_s)) begin
                    n_err++;
                    $display("FAIL mread_reset[%0d] got %h want %h", c, s,
                             (c == 6) ? fs : def_s);
                end
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        stat_m = '0;
        def_s  = '0;
        def_s.noe = 1'b1;
        def_s.nwe = 1'b1;
        test_reset();
        test_alu_sub_beq();
        test_load_wait();
        test_store();
        test_bl_ret();
        test_random();
        test_halt_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
